// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's hazard inputs, instruction-memory port and
// IF/ID outputs. The fetch stage connects through the master modport; the
// pipeline/memory environment connects through the slave modport.
interface if_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  // Hazard unit / EXE controls
  logic                  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  // Instruction memory port
  logic [DATA_WIDTH-1:0] im_addr;
  logic                  im_oe;
  logic [DATA_WIDTH-1:0] im_rdata;
  // IF/ID register towards decode
  logic [DATA_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_instr;
  logic                  id_valid;
  logic [DATA_WIDTH-1:0] fetch_cnt;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, im_rdata,
    output im_addr, im_oe, id_pc, id_instr, id_valid, fetch_cnt
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, im_rdata,
    input  im_addr, im_oe, id_pc, id_instr, id_valid, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, addresses a synchronous-read instruction memory with the
// next PC so the returned word lines up with the PC register, and applies
// load-use stall, IF/ID flush and branch/jump redirect. A one-cycle BOOT
// state after reset covers the first memory read, whose data is untrusted.
module if_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst,
  if_fetch_stage_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] CNT_STEP = DATA_WIDTH'(1);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] id_pc_reg;
  logic [DATA_WIDTH-1:0] id_instr_reg;
  logic                  id_valid_reg;
  logic [DATA_WIDTH-1:0] fetch_cnt_reg;

  // Next-PC select: reset vector during reset, hold in BOOT, then
  // redirect (word-aligned) over stall over sequential increment.
  always_comb begin
    pc_next = pc_reg;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (state_reg == RUN) begin
      if (bus.redirect_valid) begin
        pc_next = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (bus.stall) begin
        pc_next = pc_reg;
      end else begin
        pc_next = pc_reg + PC_STEP;
      end
    end
  end

  // FSM, PC register, IF/ID register and delivered-instruction counter.
  // In RUN a redirect or flush squashes IF/ID even when stalled; a stall
  // alone freezes IF/ID; otherwise the word for pc_reg is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      id_pc_reg     <= '0;
      id_instr_reg  <= NOP_INSTR;
      id_valid_reg  <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      case (state_reg)
        BOOT: begin
          state_reg    <= RUN;
          id_pc_reg    <= '0;
          id_instr_reg <= NOP_INSTR;
          id_valid_reg <= 1'b0;
        end
        RUN: begin
          if (bus.redirect_valid || bus.flush) begin
            id_pc_reg    <= '0;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
          end else if (!bus.stall) begin
            id_pc_reg     <= pc_reg;
            id_instr_reg  <= bus.im_rdata;
            id_valid_reg  <= 1'b1;
            fetch_cnt_reg <= fetch_cnt_reg + CNT_STEP;
          end
        end
        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

  // The memory samples the address at the edge, so it is fed pc_next.
  assign bus.im_addr   = pc_next;
  assign bus.im_oe     = !rst;
  assign bus.id_pc     = id_pc_reg;
  assign bus.id_instr  = id_instr_reg;
  assign bus.id_valid  = id_valid_reg;
  assign bus.fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: one instance at RESET_PC=0 for the main
// scenarios, a second at RESET_PC=FFFF_FFF8 for PC wrap-around. Each cycle
// the expected IF/ID contents are queued as stimulus is driven and popped
// and compared after the clock edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] IMKEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  if_fetch_stage_if #(.DATA_WIDTH(32)) bus0 ();
  if_fetch_stage_if #(.DATA_WIDTH(32)) bus1 ();

  if_fetch_stage #(
    .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0)
  );

  if_fetch_stage #(
    .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)
  ) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory models: data = addr ^ A5A5_0000
  always @(posedge clk) if (bus0.im_oe) bus0.im_rdata <= bus0.im_addr ^ IMKEY;
  always @(posedge clk) if (bus1.im_oe) bus1.im_rdata <= bus1.im_addr ^ IMKEY;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] im(input logic [31:0] a);
    return a ^ IMKEY;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle on the selected DUT. Called at a falling edge: drives
  // inputs, checks im_addr/im_oe before the edge, queues the IF/ID result
  // expected after the edge, then compares it at the next falling edge.
  task automatic cyc(input string tag, input bit sel, input bit r, input bit st,
                     input bit fl, input bit rv, input logic [31:0] rpc,
                     input logic [31:0] e_addr, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input bit e_valid,
                     input logic [31:0] e_cnt);
    exp_t e;
    exp_t g;
    if (sel) begin
      rst1 = r; bus1.stall = st; bus1.flush = fl;
      bus1.redirect_valid = rv; bus1.redirect_pc = rpc;
    end else begin
      rst0 = r; bus0.stall = st; bus0.flush = fl;
      bus0.redirect_valid = rv; bus0.redirect_pc = rpc;
    end
    e.pc = e_pc; e.instr = e_instr; e.valid = e_valid; e.cnt = e_cnt;
    exp_q.push_back(e);
    #1;
    check({tag, ".im_addr"}, sel ? bus1.im_addr : bus0.im_addr, e_addr);
    check({tag, ".im_oe"}, {31'd0, sel ? bus1.im_oe : bus0.im_oe}, {31'd0, !r});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      g.pc    = sel ? bus1.id_pc     : bus0.id_pc;
      g.instr = sel ? bus1.id_instr  : bus0.id_instr;
      g.valid = sel ? bus1.id_valid  : bus0.id_valid;
      g.cnt   = sel ? bus1.fetch_cnt : bus0.fetch_cnt;
      check({tag, ".id_pc"}, g.pc, e.pc);
      check({tag, ".id_instr"}, g.instr, e.instr);
      check({tag, ".id_valid"}, {31'd0, g.valid}, {31'd0, e.valid});
      check({tag, ".fetch_cnt"}, g.cnt, e.cnt);
      $display("cycle %-10s sel=%0d id_pc=%h id_instr=%h id_valid=%0d fetch_cnt=%0d",
               tag, sel, g.pc, g.instr, g.valid, g.cnt);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.stall = 0; bus0.flush = 0; bus0.redirect_valid = 0; bus0.redirect_pc = '0;
    bus1.stall = 0; bus1.flush = 0; bus1.redirect_valid = 0; bus1.redirect_pc = '0;
    @(negedge clk);

    // Reset release: rst high 3 cycles, one BOOT cycle, then fetch starts
    for (int i = 0; i < 3; i++)
      cyc("rst", 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, NOP, 0, 0);
    cyc("boot", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, NOP, 0, 0);
    cyc("run0", 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, im(32'h0), 1, 1);
    cyc("run4", 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, im(32'h4), 1, 2);

    // Stall two cycles with pc=8: IF/ID and im_addr hold
    cyc("stall1", 0, 0, 1, 0, 0, 0, 32'h8, 32'h4, im(32'h4), 1, 2);
    cyc("stall2", 0, 0, 1, 0, 0, 0, 32'h8, 32'h4, im(32'h4), 1, 2);
    cyc("run8", 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, im(32'h8), 1, 3);
    cyc("runC", 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, im(32'hC), 1, 4);
    cyc("run10", 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, im(32'h10), 1, 5);

    // Redirect together with stall: redirect wins, one bubble
    cyc("rdr_st", 0, 0, 1, 0, 1, 32'h100, 32'h100, 32'h0, NOP, 0, 5);
    cyc("run100", 0, 0, 0, 0, 0, 0, 32'h104, 32'h100, im(32'h100), 1, 6);

    // Flush alone, then flush while stalled: bubble, PC behaves normally
    cyc("flush", 0, 0, 0, 1, 0, 0, 32'h108, 32'h0, NOP, 0, 6);
    cyc("run108", 0, 0, 0, 0, 0, 0, 32'h10C, 32'h108, im(32'h108), 1, 7);
    cyc("fl_st", 0, 0, 1, 1, 0, 0, 32'h10C, 32'h0, NOP, 0, 7);
    cyc("run10C", 0, 0, 0, 0, 0, 0, 32'h110, 32'h10C, im(32'h10C), 1, 8);

    // Misaligned redirect: low bits cleared, bubble not counted
    cyc("rdr_mis", 0, 0, 0, 0, 1, 32'h103, 32'h100, 32'h0, NOP, 0, 8);
    cyc("runm100", 0, 0, 0, 0, 0, 0, 32'h104, 32'h100, im(32'h100), 1, 9);

    // Reset mid-run with pc=0x40; BOOT ignores hazard inputs
    cyc("rdr40", 0, 0, 0, 0, 1, 32'h40, 32'h40, 32'h0, NOP, 0, 9);
    cyc("rst_mid", 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, NOP, 0, 0);
    cyc("boot2", 0, 0, 1, 1, 1, 32'h200, 32'h0, 32'h0, NOP, 0, 0);
    cyc("r2run0", 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, im(32'h0), 1, 1);
    cyc("r2run4", 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, im(32'h4), 1, 2);

    // PC wrap on the second instance
    cyc("w_rst", 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    cyc("w_boot", 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    cyc("w_run0", 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, im(32'hFFFF_FFF8), 1, 1);
    cyc("w_run1", 1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, im(32'hFFFF_FFFC), 1, 2);
    cyc("w_run2", 1, 0, 0, 0, 0, 0, 32'h4, 32'h0, im(32'h0), 1, 3);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard leftover got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
